// File: rtl/circuito_jogo_param_if.sv
// Player, sequence-load and debug signals of the memory-game core.
// The board wrapper (or bench) drives through master; the game core uses slave.
interface circuito_jogo_param_if #(
  parameter int N_CHAVES = 4,
  parameter int PROF     = 16
);
  localparam int AW = $clog2(PROF);

  logic                iniciar;
  logic                modo;
  logic [N_CHAVES-1:0] chaves;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [N_CHAVES-1:0] mem_data;

  logic                acertou;
  logic                errou;
  logic                timeout;
  logic                pronto;
  logic [N_CHAVES-1:0] leds;
  logic [3:0]          db_estado;
  logic [AW-1:0]       db_endereco;
  logic [AW-1:0]       db_rodada;
  logic [N_CHAVES-1:0] db_jogada;
  logic                db_igual;
  logic                db_tem_jogada;

  modport master (
    output iniciar, modo, chaves, mem_we, mem_addr, mem_data,
    input  acertou, errou, timeout, pronto, leds, db_estado,
           db_endereco, db_rodada, db_jogada, db_igual, db_tem_jogada
  );

  modport slave (
    input  iniciar, modo, chaves, mem_we, mem_addr, mem_data,
    output acertou, errou, timeout, pronto, leds, db_estado,
           db_endereco, db_rodada, db_jogada, db_igual, db_tem_jogada
  );
endinterface

// File: rtl/circuito_jogo_param.sv
// Memory-game core: loadable sequence, edge-detected key plays, single-pass
// or progressive-round play with a per-play timeout and debug taps.
module circuito_jogo_param #(
  parameter int N_CHAVES       = 4,
  parameter int PROF           = 16,
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic                  clock,
  input  logic                  reset,
  circuito_jogo_param_if.slave  bus
);
  localparam int AW = $clog2(PROF);
  localparam int TW = $clog2(TIMEOUT_CICLOS);

  localparam logic [TW-1:0] CNT_MAX = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [AW-1:0] ULTIMO  = AW'(PROF - 1);
  localparam logic [AW:0]   PROF_W  = (AW+1)'(PROF);

  localparam logic [3:0] S_INICIAL     = 4'h0;
  localparam logic [3:0] S_PREPARACAO  = 4'h1;
  localparam logic [3:0] S_ESPERA      = 4'h2;
  localparam logic [3:0] S_REGISTRA    = 4'h3;
  localparam logic [3:0] S_COMPARA     = 4'h4;
  localparam logic [3:0] S_PROX_JOGADA = 4'h5;
  localparam logic [3:0] S_PROX_RODADA = 4'h6;
  localparam logic [3:0] S_FIM_ACERTO  = 4'hA;
  localparam logic [3:0] S_FIM_TIMEOUT = 4'hD;
  localparam logic [3:0] S_FIM_ERRO    = 4'hE;

  logic [3:0]          estado_q,   estado_d;
  logic [AW-1:0]       endereco_q, endereco_d;
  logic [AW-1:0]       rodada_q,   rodada_d;
  logic [N_CHAVES-1:0] jogada_q,   jogada_d;
  logic [TW-1:0]       cnt_q,      cnt_d;
  logic [N_CHAVES-1:0] chaves_ant_q;
  logic [N_CHAVES-1:0] mem_q [PROF];

  logic                tem_jogada_s;
  logic                igual_s;
  logic                fim_s;
  logic                escrita_ok_s;
  logic [N_CHAVES-1:0] mem_atual_s;

  assign tem_jogada_s = (|bus.chaves) & ~(|chaves_ant_q);
  assign mem_atual_s  = mem_q[endereco_q];
  assign igual_s      = (jogada_q == mem_atual_s);
  assign fim_s        = (estado_q == S_FIM_ACERTO) || (estado_q == S_FIM_ERRO) ||
                        (estado_q == S_FIM_TIMEOUT);
  // Loading mid-game would change the target under the player's feet.
  assign escrita_ok_s = bus.mem_we && ((estado_q == S_INICIAL) || fim_s) &&
                        ({1'b0, bus.mem_addr} < PROF_W);

  // Next-state and datapath decisions of the game FSM.
  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    rodada_d   = rodada_q;
    jogada_d   = jogada_q;
    cnt_d      = cnt_q;
    case (estado_q)
      S_INICIAL: begin
        if (bus.iniciar) begin
          estado_d = S_PREPARACAO;
        end else begin
          estado_d = S_INICIAL;
        end
      end
      S_PREPARACAO: begin
        endereco_d = '0;
        jogada_d   = '0;
        cnt_d      = '0;
        if (bus.modo) begin
          rodada_d = '0;
        end else begin
          rodada_d = ULTIMO;
        end
        estado_d = S_ESPERA;
      end
      S_ESPERA: begin
        if (tem_jogada_s) begin
          estado_d = S_REGISTRA;
        end else if (cnt_q == CNT_MAX) begin
          estado_d = S_FIM_TIMEOUT;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_REGISTRA: begin
        jogada_d = bus.chaves;
        estado_d = S_COMPARA;
      end
      S_COMPARA: begin
        if (!igual_s) begin
          estado_d = S_FIM_ERRO;
        end else if (endereco_q != rodada_q) begin
          estado_d = S_PROX_JOGADA;
        end else if (rodada_q == ULTIMO) begin
          estado_d = S_FIM_ACERTO;
        end else begin
          estado_d = S_PROX_RODADA;
        end
      end
      S_PROX_JOGADA: begin
        endereco_d = endereco_q + AW'(1);
        cnt_d      = '0;
        estado_d   = S_ESPERA;
      end
      S_PROX_RODADA: begin
        rodada_d   = rodada_q + AW'(1);
        endereco_d = '0;
        cnt_d      = '0;
        estado_d   = S_ESPERA;
      end
      S_FIM_ACERTO, S_FIM_ERRO, S_FIM_TIMEOUT: begin
        if (bus.iniciar) begin
          estado_d = S_PREPARACAO;
        end else begin
          estado_d = estado_q;
        end
      end
      default: begin
        estado_d = S_INICIAL;
      end
    endcase
  end

  // FSM state, counters, play register and key history.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q     <= S_INICIAL;
      endereco_q   <= '0;
      rodada_q     <= '0;
      jogada_q     <= '0;
      cnt_q        <= '0;
      chaves_ant_q <= '0;
    end else begin
      estado_q     <= estado_d;
      endereco_q   <= endereco_d;
      rodada_q     <= rodada_d;
      jogada_q     <= jogada_d;
      cnt_q        <= cnt_d;
      chaves_ant_q <= bus.chaves;
    end
  end

  // Sequence storage survives reset so a loaded game can be replayed.
  always_ff @(posedge clock) begin
    if (escrita_ok_s) begin
      mem_q[bus.mem_addr] <= bus.mem_data;
    end else begin
      mem_q[bus.mem_addr] <= mem_q[bus.mem_addr];
    end
  end

  assign bus.acertou       = (estado_q == S_FIM_ACERTO);
  assign bus.errou         = (estado_q == S_FIM_ERRO) || (estado_q == S_FIM_TIMEOUT);
  assign bus.timeout       = (estado_q == S_FIM_TIMEOUT);
  assign bus.pronto        = fim_s;
  assign bus.leds          = mem_atual_s;
  assign bus.db_estado     = estado_q;
  assign bus.db_endereco   = endereco_q;
  assign bus.db_rodada     = rodada_q;
  assign bus.db_jogada     = jogada_q;
  assign bus.db_igual      = igual_s;
  assign bus.db_tem_jogada = tem_jogada_s;
endmodule

// File: tb/tb_circuito_jogo_param.sv
// Directed bench for circuito_jogo_param: N=4, PROF=4, TIMEOUT_CICLOS=8.
module tb_circuito_jogo_param;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [3:0] st_res;
  logic       igual_res;
  int   visitas_rodada;

  circuito_jogo_param_if #(.N_CHAVES(4), .PROF(4)) bus ();

  circuito_jogo_param #(
    .N_CHAVES(4), .PROF(4), .TIMEOUT_CICLOS(8)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after entry into espera_jogada.
  task automatic start(input logic m);
    bus.iniciar = 1'b1;
    bus.modo    = m;
    @(negedge clk);
    bus.iniciar = 1'b0;
    check_eq("prep_estado", 32'(bus.db_estado), 32'h1);
    check_eq("prep_flags", 32'({bus.acertou, bus.errou, bus.pronto}), 32'h0);
    @(negedge clk);
    check_eq("espera_estado", 32'(bus.db_estado), 32'h2);
    check_eq("espera_rodada", 32'(bus.db_rodada), m ? 32'h0 : 32'h3);
    check_eq("espera_end", 32'(bus.db_endereco), 32'h0);
  endtask

  // Press k for two edges, release, return after the post-compare state.
  task automatic play(input logic [3:0] k);
    bus.chaves = k;
    @(negedge clk);
    @(negedge clk);
    igual_res  = bus.db_igual;
    bus.chaves = 4'h0;
    @(negedge clk);
    st_res = bus.db_estado;
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    visitas_rodada = 0;
    rst_n        = 1'b0;
    bus.iniciar  = 1'b0;
    bus.modo     = 1'b0;
    bus.chaves   = 4'h0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 2'd0;
    bus.mem_data = 4'h0;
    #3;
    check_eq("rst_estado", 32'(bus.db_estado), 32'h0);
    check_eq("rst_flags", 32'({bus.acertou, bus.errou, bus.timeout, bus.pronto}), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      bus.mem_we   = 1'b1;
      bus.mem_addr = 2'(i);
      bus.mem_data = 4'(1 << i);
      @(negedge clk);
    end
    bus.mem_we = 1'b0;
    check_eq("load_leds", 32'(bus.leds), 32'h1);

    // Single pass, all correct.
    start(1'b0);
    play(4'h1);
    check_eq("p1_igual", 32'(igual_res), 32'h1);
    check_eq("p1_res", 32'(st_res), 32'h5);
    check_eq("p1_end", 32'(bus.db_endereco), 32'h1);
    play(4'h2);
    check_eq("p2_res", 32'(st_res), 32'h5);
    play(4'h4);
    check_eq("p3_res", 32'(st_res), 32'h5);
    play(4'h8);
    check_eq("p4_res", 32'(st_res), 32'hA);
    check_eq("ok_estado", 32'(bus.db_estado), 32'hA);
    check_eq("ok_flags", 32'({bus.acertou, bus.errou, bus.timeout, bus.pronto}), 32'b1001);
    check_eq("ok_rodada", 32'(bus.db_rodada), 32'h3);
    check_eq("ok_leds", 32'(bus.leds), 32'h8);

    // Write in a final state is visible next cycle, then restore.
    bus.mem_we = 1'b1; bus.mem_addr = 2'd3; bus.mem_data = 4'h1;
    @(negedge clk);
    check_eq("wr_vis", 32'(bus.leds), 32'h1);
    bus.mem_data = 4'h8;
    @(negedge clk);
    bus.mem_we = 1'b0;
    check_eq("wr_restore", 32'(bus.leds), 32'h8);

    // Single pass, wrong third play.
    start(1'b0);
    play(4'h1);
    play(4'h2);
    play(4'h8);
    check_eq("err_igual", 32'(igual_res), 32'h0);
    check_eq("err_res", 32'(st_res), 32'hE);
    check_eq("err_flags", 32'({bus.acertou, bus.errou, bus.timeout, bus.pronto}), 32'b0101);
    check_eq("err_end", 32'(bus.db_endereco), 32'h2);
    check_eq("err_jogada", 32'(bus.db_jogada), 32'h8);

    // Progressive rounds.
    start(1'b1);
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j <= r; j++) begin
        play(4'(1 << j));
        check_eq("rd_igual", 32'(igual_res), 32'h1);
        if (j < r) begin
          check_eq("rd_pj", 32'(st_res), 32'h5);
        end else if (r < 3) begin
          check_eq("rd_pr", 32'(st_res), 32'h6);
          visitas_rodada = visitas_rodada + 1;
          check_eq("rd_end0", 32'(bus.db_endereco), 32'h0);
          check_eq("rd_rodada", 32'(bus.db_rodada), 32'(r + 1));
        end else begin
          check_eq("rd_fim", 32'(st_res), 32'hA);
        end
      end
    end
    check_eq("rd_visitas", 32'(visitas_rodada), 32'h3);
    check_eq("rd_acertou", 32'(bus.acertou), 32'h1);

    // Timeout with no press.
    start(1'b0);
    repeat (7) @(negedge clk);
    check_eq("to_pre_estado", 32'(bus.db_estado), 32'h2);
    check_eq("to_pre_flag", 32'(bus.timeout), 32'h0);
    @(negedge clk);
    check_eq("to_estado", 32'(bus.db_estado), 32'hD);
    check_eq("to_flags", 32'({bus.acertou, bus.errou, bus.timeout, bus.pronto}), 32'b0111);

    // Press on the last allowed cycle wins over timeout.
    start(1'b0);
    repeat (7) @(negedge clk);
    bus.chaves = 4'h1;
    #1;
    check_eq("prio_edge", 32'(bus.db_tem_jogada), 32'h1);
    @(negedge clk);
    check_eq("prio_estado", 32'(bus.db_estado), 32'h3);
    @(negedge clk);
    bus.chaves = 4'h0;
    @(negedge clk);
    check_eq("prio_res", 32'(bus.db_estado), 32'h5);
    @(negedge clk);
    play(4'h3);
    check_eq("multi_res", 32'(st_res), 32'hE);
    check_eq("multi_errou", 32'(bus.errou), 32'h1);

    // Key held across proxima_jogada gives no second play.
    start(1'b0);
    bus.chaves = 4'h1;
    repeat (3) @(negedge clk);
    check_eq("hold_res", 32'(bus.db_estado), 32'h5);
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      check_eq("hold_estado", 32'(bus.db_estado), 32'h2);
      check_eq("hold_edge", 32'(bus.db_tem_jogada), 32'h0);
    end
    bus.chaves = 4'h0;
    @(negedge clk);
    play(4'h2);
    check_eq("hold_p2", 32'(st_res), 32'h5);

    // Asynchronous reset in compara.
    bus.chaves = 4'h4;
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_estado", 32'(bus.db_estado), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_estado", 32'(bus.db_estado), 32'h0);
    check_eq("arst_flags", 32'({bus.acertou, bus.errou, bus.timeout, bus.pronto}), 32'h0);
    check_eq("arst_cnts", 32'({bus.db_endereco, bus.db_rodada, bus.db_jogada}), 32'h0);
    check_eq("arst_mem", 32'(bus.leds), 32'h1);
    bus.chaves = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;

    // Writes during play are ignored; same sequence still wins.
    start(1'b0);
    bus.mem_we = 1'b1; bus.mem_addr = 2'd0; bus.mem_data = 4'h4;
    @(negedge clk);
    bus.mem_we = 1'b0;
    check_eq("we_ign", 32'(bus.leds), 32'h1);
    play(4'h1);
    play(4'h2);
    play(4'h4);
    play(4'h8);
    check_eq("fresh_res", 32'(st_res), 32'hA);
    check_eq("fresh_acertou", 32'(bus.acertou), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
